// File: rtl/spi_mstr.sv
// spi_mstr: mode-0 SPI bus master, 16-bit full-duplex transfers with five decoded active-low selects.
// Build option SPI_MISO_SYNC_EN inserts a two-flop synchronizer on MISO ahead of the RX shifter.
module spi_mstr #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_SPI,
  input  logic [15:0] SPI_data,
  input  logic [2:0]  ss,
  input  logic        MISO,
  output logic        SCLK,
  output logic        MOSI,
  output logic        ch1_ss_n,
  output logic        ch2_ss_n,
  output logic        ch3_ss_n,
  output logic        EEP_ss_n,
  output logic        trig_ss_n,
  output logic        SPI_done,
  output logic [15:0] rd_data
);

  localparam int H = SCLK_DIV / 2;
  localparam int HC_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [HC_W-1:0] H_LAST = HC_W'(H - 1);

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  state_t          state, nxt_state;
  logic [HC_W-1:0] h_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     tx_sr;
  logic [15:0]     rx_sr;
  logic [4:0]      sel_n;
  logic            miso_s;
  logic            h_last;
  logic            accept;
  logic            rise;
  logic            fall;
  logic            last_fall;
  logic            finish;

  // Select vector order is {trig, EEP, ch3, ch2, ch1}; unlisted codes select nothing.
  function automatic logic [4:0] decode_sel(input logic [2:0] code);
    case (code)
      3'b001:  decode_sel = 5'b11110;
      3'b010:  decode_sel = 5'b11101;
      3'b011:  decode_sel = 5'b11011;
      3'b100:  decode_sel = 5'b10111;
      3'b111:  decode_sel = 5'b01111;
      default: decode_sel = 5'b11111;
    endcase
  endfunction

`ifdef SPI_MISO_SYNC_EN
  logic miso_m1;
  logic miso_m2;

  always_ff @(posedge clk) begin
    miso_m1 <= MISO;
    miso_m2 <= miso_m1;
  end

  assign miso_s = miso_m2;
`else
  assign miso_s = MISO;
`endif

  assign h_last    = (h_cnt == H_LAST);
  assign last_fall = fall && (bit_cnt == 4'hF);

  always_comb begin
    nxt_state = state;
    accept    = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (wrt_SPI) begin
          accept    = 1'b1;
          nxt_state = FRONT;
        end
      end
      FRONT: begin
        if (h_last) begin
          rise      = 1'b1;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (h_last) begin
          if (!SCLK) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == 4'hF) nxt_state = BACK;
          end
        end
      end
      BACK: begin
        if (h_last) begin
          finish    = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // bit_cnt advances on each fall, so it equals the index of the rise just completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      bit_cnt  <= '0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      sel_n    <= '1;
      SPI_done <= 1'b0;
      rd_data  <= '0;
    end else begin
      SPI_done <= finish;

      if (accept || h_last)  h_cnt <= '0;
      else if (state != IDLE) h_cnt <= h_cnt + 1'b1;

      if (accept)    bit_cnt <= '0;
      else if (fall) bit_cnt <= bit_cnt + 1'b1;

      if (rise)      SCLK <= 1'b1;
      else if (fall) SCLK <= 1'b0;

      if (accept)                  MOSI <= SPI_data[15];
      else if (fall && !last_fall) MOSI <= tx_sr[14];
      else if (finish)             MOSI <= 1'b0;

      if (accept)      sel_n <= decode_sel(ss);
      else if (finish) sel_n <= '1;

      if (finish) rd_data <= rx_sr;
    end
  end

  // Shift registers carry data only; every bit is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (accept)                  tx_sr <= SPI_data;
    else if (fall && !last_fall) tx_sr <= {tx_sr[14:0], 1'b0};

    if (rise) rx_sr <= {rx_sr[14:0], miso_s};
  end

  assign {trig_ss_n, EEP_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n} = sel_n;

endmodule

// File: tb/tb_spi_mstr.sv
// Directed bench for spi_mstr: reset, per-slave transfers, ignored requests, back-to-back and mid-transfer reset.
module tb_spi_mstr;

  localparam int SCLK_DIV = 32;
  localparam int H        = SCLK_DIV / 2;
  localparam int DONE_CYC = 1 + 33 * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt_SPI = 1'b0;
  logic [15:0] SPI_data = 16'h0000;
  logic [2:0]  ss = 3'b000;
  logic        MISO = 1'b0;
  logic        SCLK, MOSI;
  logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, EEP_ss_n, trig_ss_n;
  logic        SPI_done;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  int          done_cyc, rises, first_rise, last_fall_cyc, multi_low;
  int          sel_cnt[5];
  int          sel_first[5];
  int          sel_last[5];
  logic [15:0] mosi_bits, rd_at_done, slave_word;
  logic [4:0]  sel_n_vec;

  assign sel_n_vec = {trig_ss_n, EEP_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

  spi_mstr #(.SCLK_DIV(SCLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt_SPI  (wrt_SPI),
    .SPI_data (SPI_data),
    .ss       (ss),
    .MISO     (MISO),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .ch1_ss_n (ch1_ss_n),
    .ch2_ss_n (ch2_ss_n),
    .ch3_ss_n (ch3_ss_n),
    .EEP_ss_n (EEP_ss_n),
    .trig_ss_n(trig_ss_n),
    .SPI_done (SPI_done),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] s, input logic [15:0] d, input logic [15:0] sw);
    @(negedge clk);
    ss         = s;
    SPI_data   = d;
    wrt_SPI    = 1'b1;
    slave_word = sw;
  endtask

  // Consumes the accept edge, then watches cycles 1..max_cyc; the slave shifts its word out MSB-first on falls.
  task automatic observe(input int max_cyc, input int inj_cyc, input logic [2:0] inj_ss,
                         input logic [15:0] inj_d, input bit inj_hold);
    logic prev_sclk;
    int   m;
    @(posedge clk);
    #1;
    wrt_SPI       = 1'b0;
    MISO          = slave_word[15];
    m             = 14;
    prev_sclk     = 1'b0;
    done_cyc      = -1;
    rises         = 0;
    first_rise    = -1;
    last_fall_cyc = -1;
    multi_low     = 0;
    mosi_bits     = 16'h0000;
    rd_at_done    = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      sel_cnt[i]   = 0;
      sel_first[i] = -1;
      sel_last[i]  = -1;
    end
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        ss       = inj_ss;
        SPI_data = inj_d;
        wrt_SPI  = 1'b1;
      end else if (c == inj_cyc + 1 && !inj_hold) begin
        wrt_SPI = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (!sel_n_vec[i]) begin
          sel_cnt[i]++;
          if (sel_first[i] < 0) sel_first[i] = c;
          sel_last[i] = c;
        end
      end
      if ($countones(~sel_n_vec) > 1) multi_low++;
      if (SCLK && !prev_sclk) begin
        if (first_rise < 0) first_rise = c;
        rises++;
        mosi_bits = {mosi_bits[14:0], MOSI};
      end
      if (!SCLK && prev_sclk) begin
        last_fall_cyc = c;
        if (m >= 0) begin
          MISO = slave_word[m];
          m--;
        end
      end
      prev_sclk = SCLK;
      if (SPI_done) begin
        done_cyc   = c;
        rd_at_done = rd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (sel_n_vec !== 5'b11111) begin errors++; $display("FAIL reset_sel: got %b expected 11111", sel_n_vec); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
    checks++; if (SPI_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", SPI_done); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_ch1();
    issue(3'b001, 16'h1302, 16'h0000);
    observe(600, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL ch1_done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (sel_first[0] != 1 || sel_last[0] != DONE_CYC - 1) begin errors++; $display("FAIL ch1_sel_window: got %0d..%0d expected 1..%0d", sel_first[0], sel_last[0], DONE_CYC - 1); end
    checks++; if (sel_cnt[0] != DONE_CYC - 1) begin errors++; $display("FAIL ch1_sel_count: got %0d expected %0d", sel_cnt[0], DONE_CYC - 1); end
    checks++; if (sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4] != 0) begin errors++; $display("FAIL ch1_other_sel: got %0d low cycles expected 0", sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4]); end
    checks++; if (mosi_bits !== 16'h1302) begin errors++; $display("FAIL ch1_mosi: got %h expected 1302", mosi_bits); end
    checks++; if (rises != 16) begin errors++; $display("FAIL ch1_rises: got %0d expected 16", rises); end
    checks++; if (first_rise != 1 + H) begin errors++; $display("FAIL ch1_first_rise: got %0d expected %0d", first_rise, 1 + H); end
    checks++; if (last_fall_cyc != 1 + 32 * H) begin errors++; $display("FAIL ch1_last_fall: got %0d expected %0d", last_fall_cyc, 1 + 32 * H); end
    checks++; if (rd_at_done !== 16'h0000) begin errors++; $display("FAIL ch1_rd_data: got %h expected 0000", rd_at_done); end
    @(negedge clk);
    checks++; if (SPI_done !== 1'b0) begin errors++; $display("FAIL ch1_done_width: got %b expected 0", SPI_done); end
  endtask

  task automatic test_eeprom();
    issue(3'b100, 16'h0000, 16'hA5C3);
    observe(600, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL eep_done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (sel_cnt[3] != DONE_CYC - 1 || sel_first[3] != 1) begin errors++; $display("FAIL eep_sel: got %0d cycles from %0d expected %0d from 1", sel_cnt[3], sel_first[3], DONE_CYC - 1); end
    checks++; if (rd_at_done !== 16'hA5C3) begin errors++; $display("FAIL eep_rd_data: got %h expected a5c3", rd_at_done); end
    repeat (5) @(negedge clk);
    checks++; if (rd_data !== 16'hA5C3) begin errors++; $display("FAIL eep_rd_hold: got %h expected a5c3", rd_data); end
  endtask

  task automatic test_ignore();
    int bad;
    issue(3'b111, 16'h00EF, 16'h0000);
    observe(600, 100, 3'b001, 16'hFFFF, 1'b0);
    checks++; if (mosi_bits !== 16'h00EF) begin errors++; $display("FAIL ign_mosi: got %h expected 00ef", mosi_bits); end
    checks++; if (sel_cnt[4] != DONE_CYC - 1) begin errors++; $display("FAIL ign_trig_sel: got %0d expected %0d", sel_cnt[4], DONE_CYC - 1); end
    checks++; if (sel_cnt[0] != 0) begin errors++; $display("FAIL ign_ch1_sel: got %0d expected 0", sel_cnt[0]); end
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL ign_done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (SCLK !== 1'b0 || sel_n_vec !== 5'b11111) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_stays_idle: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    issue(3'b100, 16'h0A00, 16'h3C5A);
    observe(600, 520, 3'b100, 16'h0000, 1'b1);
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL b2b_first_done: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (mosi_bits !== 16'h0A00) begin errors++; $display("FAIL b2b_first_mosi: got %h expected 0a00", mosi_bits); end
    checks++; if (rd_at_done !== 16'h3C5A) begin errors++; $display("FAIL b2b_first_rd: got %h expected 3c5a", rd_at_done); end
    slave_word = 16'h5A81;
    observe(600, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (sel_first[3] != 1) begin errors++; $display("FAIL b2b_second_sel: got %0d expected 1", sel_first[3]); end
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (mosi_bits !== 16'h0000) begin errors++; $display("FAIL b2b_second_mosi: got %h expected 0000", mosi_bits); end
    checks++; if (rd_at_done !== 16'h5A81) begin errors++; $display("FAIL b2b_second_rd: got %h expected 5a81", rd_at_done); end
  endtask

  task automatic test_no_slave();
    issue(3'b000, 16'h1234, 16'h0000);
    observe(600, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (sel_cnt[0] + sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4] != 0) begin errors++; $display("FAIL nosl_sel: got %0d low cycles expected 0", sel_cnt[0] + sel_cnt[1] + sel_cnt[2] + sel_cnt[3] + sel_cnt[4]); end
    checks++; if (rises != 16) begin errors++; $display("FAIL nosl_rises: got %0d expected 16", rises); end
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL nosl_done_cycle: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (mosi_bits !== 16'h1234) begin errors++; $display("FAIL nosl_mosi: got %h expected 1234", mosi_bits); end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(3'b010, 16'hFFFF, 16'h0000);
    observe(185, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (SCLK !== 1'b1 || ch2_ss_n !== 1'b0) begin errors++; $display("FAIL rmid_pre: got sclk=%b ch2_ss_n=%b expected 1 0", SCLK, ch2_ss_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (ch2_ss_n !== 1'b1) begin errors++; $display("FAIL rmid_ch2_ss_n: got %b expected 1", ch2_ss_n); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL rmid_sclk: got %b expected 0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rmid_mosi: got %b expected 0", MOSI); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (SPI_done !== 1'b0) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (SPI_done !== 1'b0 || sel_n_vec !== 5'b11111) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", seen); end
    issue(3'b010, 16'h00FF, 16'h1234);
    observe(600, -1, 3'b000, 16'h0000, 1'b0);
    checks++; if (done_cyc != DONE_CYC) begin errors++; $display("FAIL rmid_after_done: got %0d expected %0d", done_cyc, DONE_CYC); end
    checks++; if (sel_first[1] != 1 || sel_cnt[1] != DONE_CYC - 1) begin errors++; $display("FAIL rmid_after_sel: got %0d cycles from %0d expected %0d from 1", sel_cnt[1], sel_first[1], DONE_CYC - 1); end
    checks++; if (rd_at_done !== 16'h1234) begin errors++; $display("FAIL rmid_after_rd: got %h expected 1234", rd_at_done); end
    checks++; if (multi_low != 0) begin errors++; $display("FAIL rmid_one_hot: got %0d multi-select cycles expected 0", multi_low); end
  endtask

  initial begin
    test_reset();
    test_ch1();
    test_eeprom();
    test_ignore();
    test_back_to_back();
    test_no_slave();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mstr.md
# spi_mstr

Bus master for the DSO's shared SPI bus, directly downstream of the command dispatcher. For each `wrt_SPI` request it latches a 16-bit word and a 3-bit slave code. It then drives one active-low slave select and shifts the word out MSB-first on MOSI while capturing 16 bits from MISO. It signals completion with a one-cycle `SPI_done` and exposes the captured word for EEPROM read responses.

## Interface
- `SCLK_DIV`, default 32: `clk` periods per SCLK period; must be even and ≥ 4. H = `SCLK_DIV`/2.
- `clk` input 1: system clock. One clock only; every flop is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `wrt_SPI` input 1: start request, level-sampled each cycle.
- `SPI_data` input 16: word to transmit, latched with `wrt_SPI`.
- `ss` input 3: slave code, latched with `wrt_SPI`.
  - 001 = ch1, 010 = ch2, 011 = ch3, 100 = EEPROM, 111 = trigger DAC.
  - Any other code = no slave.
- `MISO` input 1: serial data from the selected slave.
- `SCLK` output 1: serial clock; idles low (mode 0).
- `MOSI` output 1: serial data out.
- `ch1_ss_n`, `ch2_ss_n`, `ch3_ss_n`, `EEP_ss_n`, `trig_ss_n` output 1 each: active-low selects, all registered.
- `SPI_done` output 1: one-cycle completion pulse.
- `rd_data` output 16: word captured from MISO; EEPROM read byte is `rd_data[7:0]`.

## Operation
- Reset values (asynchronous; also if reset asserts mid-transfer):
  - all `*_ss_n` = 1
  - `SCLK` = 0, `MOSI` = 0, `SPI_done` = 0
  - `rd_data` = 0x0000
  - state = IDLE, H-counter = 0, bit counter = 0
- FSM states: IDLE, FRONT, SHIFT, BACK.
- IDLE
  - If `wrt_SPI` = 1: load the TX shift register from `SPI_data`, latch `ss` into `ss_q`, clear the counters, go to FRONT.
  - `wrt_SPI` is accepted in the same cycle `SPI_done` is high; this gives back-to-back EEPROM read then data phases.
- FRONT
  - The select decoded from `ss_q` is low. `SCLK` stays low; MOSI = TX[15].
  - After H clocks, go to SHIFT.
- SHIFT
  - `SCLK` toggles every H clocks, starting with a rise.
  - On each rise: shift MISO into the RX register LSB-first-in, so the first bit received ends at bit 15.
  - On each fall: shift TX left by one; MOSI = new TX[15].
  - A 4-bit bit counter counts rises. On the fall that follows the 16th rise, go to BACK. TX is not shifted on that last fall.
- BACK
  - `SCLK` low, select still low, hold for H clocks.
  - Then deassert the select, copy RX to `rd_data`, pulse `SPI_done`, return to IDLE.
- `wrt_SPI` outside IDLE is ignored. `SPI_data` and `ss` may change freely after the accept cycle.
- Slave code not in the decode list: no select asserts, but the full transfer still runs and `SPI_done` still pulses.
- At most one `*_ss_n` is low at any time.

## Timing
- Cycle 0 = the cycle `wrt_SPI` is sampled high in IDLE.
- Select low and MOSI = bit 15 from cycle 1.
- SCLK rise k (k = 0..15) registered at cycle 1 + H + 2kH; the following fall at cycle 1 + 2H + 2kH.
- Last fall at cycle 1 + 32H.
- `SPI_done` high and select high at cycle 1 + 33H (529 for `SCLK_DIV` = 32).
- `rd_data` valid from the same cycle as `SPI_done`; it holds until the next completion.
- MOSI is stable for ≥ H−1 clocks before and after every SCLK rise.
- Minimum spacing between requests: 1 + 33H cycles, with back-to-back accept in the `SPI_done` cycle.

## Configuration
- `SPI_MISO_SYNC_EN` defined:
  - MISO passes through a two-flop synchronizer before the RX shift.
  - The sample at rise k reflects MISO as it was two clocks earlier. The slave must hold data ≥ 3 clocks around the rise (guaranteed for `SCLK_DIV` ≥ 8).
- Not defined:
  - MISO is sampled directly in the rise cycle.
- SCLK/MOSI/select timing is identical in both builds.

## Test plan
- ss=001, SPI_data=0x1302, MISO=0:
  - `ch1_ss_n` low cycles 1–528, all other selects high.
  - MOSI at the 16 rises = 0001_0011_0000_0010.
  - `SPI_done` pulses at cycle 529; `rd_data` = 0x0000.
- ss=100, SPI_data=0x0000, slave model returning 0xA5C3 MSB-first on falls:
  - `EEP_ss_n` low, `rd_data` = 0xA5C3 at `SPI_done`.
  - Repeat with `SPI_MISO_SYNC_EN` defined: same result.
- Start ss=111, data 0x00EF; at cycle 100 assert `wrt_SPI` with ss=001, data 0xFFFF:
  - Second request ignored; `trig_ss_n` only; MOSI pattern is 0x00EF.
- Back-to-back: ss=100, 0x0A00; hold `wrt_SPI` = 1 with 0x0000 into the `SPI_done` cycle:
  - Second transfer's `EEP_ss_n` low on the next cycle.
  - Second `SPI_done` 529 cycles after the first.
- ss=000, data 0x1234:
  - No select ever low; 16 SCLK pulses; `SPI_done` at cycle 529.
- Drop `rst_n` at cycle 200 of a ch2 transfer:
  - Same cycle: `ch2_ss_n` = 1, `SCLK` = 0, `MOSI` = 0.
  - No `SPI_done`; a new request after release completes normally.
